// File: rtl/zbuffer_depth_test.sv
// Z-buffer depth test: pops fragments from an upstream FIFO, compares each
// fragment's depth against the stored depth at its pixel address, and keeps
// the nearer one. A clear sweep initialises the buffer after reset or on
// request. Stored values can be read back through a registered port.
module zbuffer_depth_test #(
  parameter  int ADDR_W  = 4,
  parameter  int Z_W     = 6,
  parameter  int COLOR_W = 6,
  parameter  int FILL_W  = 8,
  localparam int FRAG_W  = ADDR_W + Z_W + COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FILL_W-1:0]  fill,
  input  logic [FRAG_W-1:0]  frag_in,
  input  logic               ack_in,
  output logic               req_out,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COLOR_W-1:0] color_out,
  output logic [Z_W-1:0]     depth_out,
  output logic               busy,
  output logic [15:0]        pass_cnt,
  output logic [15:0]        reject_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_TEST
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    k_q, k_d;
  logic                 pend_q, pend_d;
  logic [FRAG_W-1:0]    frag_q, frag_d;
  logic [15:0]          pass_cnt_q, pass_cnt_d;
  logic [15:0]          reject_cnt_q, reject_cnt_d;
  logic [Z_W-1:0]       depth_out_q, depth_out_d;
  logic [COLOR_W-1:0]   color_out_q, color_out_d;

  logic [Z_W-1:0]       depth_mem [DEPTH];
  logic [COLOR_W-1:0]   color_mem [DEPTH];

  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [Z_W-1:0]       mem_wz;
  logic [COLOR_W-1:0]   mem_wc;

  // Fields of the captured fragment: {addr, z, color}.
  logic [ADDR_W-1:0]    frag_addr;
  logic [Z_W-1:0]       frag_z;
  logic [COLOR_W-1:0]   frag_color;
  logic                 z_pass;

  assign frag_addr  = frag_q[FRAG_W-1 -: ADDR_W];
  assign frag_z     = frag_q[COLOR_W +: Z_W];
  assign frag_color = frag_q[COLOR_W-1:0];
  // Strictly nearer fragments win; equal depth is rejected.
  assign z_pass     = frag_z < depth_mem[frag_addr];

  // Next-state, counter, capture and memory-write decode.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    k_d          = k_q;
    pend_d       = pend_q | clear;
    frag_d       = frag_q;
    pass_cnt_d   = pass_cnt_q;
    reject_cnt_d = reject_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = k_q;
    mem_wz       = '1;
    mem_wc       = '0;

    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = k_q;
        mem_wz    = '1;
        mem_wc    = '0;
        k_d       = k_q + 1'b1;
        if (&k_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pend_q || clear) begin
          state_d      = S_CLEAR;
          k_d          = '0;
          pend_d       = 1'b0;
          pass_cnt_d   = '0;
          reject_cnt_d = '0;
        end else if (fill != '0) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ack_in) begin
          frag_d  = frag_in;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        if (z_pass) begin
          mem_we     = 1'b1;
          mem_waddr  = frag_addr;
          mem_wz     = frag_z;
          mem_wc     = frag_color;
          pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
        end else begin
          reject_cnt_d = (reject_cnt_q == 16'hFFFF) ? reject_cnt_q : reject_cnt_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        k_d     = '0;
      end
    endcase
  end

  // Readback path: combinational array read, registered on the next edge,
  // so a same-cycle write is not visible until the following read.
  always_comb begin
    depth_out_d = depth_mem[rd_addr];
    color_out_d = color_mem[rd_addr];
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the values from
    // before this edge, independent of statement order.
    if (reset) begin
      state_q      <= S_CLEAR;
      k_q          <= '0;
      pend_q       <= 1'b0;
      frag_q       <= '0;
      pass_cnt_q   <= '0;
      reject_cnt_q <= '0;
      depth_out_q  <= '0;
      color_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pend_q       <= pend_d;
      frag_q       <= frag_d;
      pass_cnt_q   <= pass_cnt_d;
      reject_cnt_q <= reject_cnt_d;
      depth_out_q  <= depth_out_d;
      color_out_q  <= color_out_d;
    end
  end

  // Buffer write port; a reset edge blocks any pending write.
  always_ff @(posedge clk) begin
    // NOTE: the arrays carry no reset; the CLEAR sweep that always follows
    // reset initialises them, which keeps them mappable to plain RAM.
    if (mem_we && !reset) begin
      depth_mem[mem_waddr] <= mem_wz;
      color_mem[mem_waddr] <= mem_wc;
    end
  end

  assign req_out    = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE);
  assign pass_cnt   = pass_cnt_q;
  assign reject_cnt = reject_cnt_q;
  assign depth_out  = depth_out_q;
  assign color_out  = color_out_q;

endmodule

// File: tb/tb_zbuffer_depth_test.sv
// Directed testbench for zbuffer_depth_test with default parameters.
module tb_zbuffer_depth_test;

  logic        clk;
  logic        reset;
  logic [7:0]  fill;
  logic [15:0] frag_in;
  logic        ack_in;
  logic        req_out;
  logic        clear;
  logic [3:0]  rd_addr;
  logic [5:0]  color_out;
  logic [5:0]  depth_out;
  logic        busy;
  logic [15:0] pass_cnt;
  logic [15:0] reject_cnt;

  int checks = 0;
  int errors = 0;

  zbuffer_depth_test dut (
    .clk        (clk),
    .reset      (reset),
    .fill       (fill),
    .frag_in    (frag_in),
    .ack_in     (ack_in),
    .req_out    (req_out),
    .clear      (clear),
    .rd_addr    (rd_addr),
    .color_out  (color_out),
    .depth_out  (depth_out),
    .busy       (busy),
    .pass_cnt   (pass_cnt),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an address and return the registered readback one cycle later.
  task automatic read_addr(input logic [3:0] a, output logic [5:0] z, output logic [5:0] c);
    rd_addr = a;
    tick();
    z = depth_out;
    c = color_out;
  endtask

  // Run one fragment from IDLE: fill, pop request, ack in WAIT, test.
  task automatic send_frag(input logic [3:0] a, input logic [5:0] z, input logic [5:0] c,
                           output int pulses);
    pulses = 0;
    fill = 8'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_out) begin
        pulses++;
        break;
      end
    end
    fill = 8'd0;
    tick();                       // now in WAIT
    if (req_out) pulses++;
    ack_in  = 1'b1;
    frag_in = {a, z, c};
    tick();                       // now in TEST
    if (req_out) pulses++;
    ack_in = 1'b0;
    tick();                       // back in IDLE
    if (req_out) pulses++;
  endtask

  // Count cycles until busy falls, bounded.
  task automatic wait_not_busy(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!busy) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [5:0] z, c;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || req_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b req_out=%b, want busy=1 req_out=0", busy, req_out);
    end
    checks++;
    if (pass_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: pass=%0d reject=%0d, want 0 0", pass_cnt, reject_cnt);
    end
    checks++;
    if (depth_out !== 6'd0 || color_out !== 6'd0) begin
      errors++;
      $display("FAIL reset_rd: depth=%h color=%h, want 0 0", depth_out, color_out);
    end
    reset = 1'b0;
    wait_not_busy(cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL reset_busy_time: busy fell after %0d cycles, want 16", cyc);
    end
    for (int a = 0; a < 16; a++) begin
      read_addr(4'(a), z, c);
      checks++;
      if (z !== 6'h3F || c !== 6'h00) begin
        errors++;
        $display("FAIL reset_sweep[%0d]: depth=%h color=%h, want 3f 00", a, z, c);
      end
    end
  endtask

  task automatic test_first_pass();
    int pulses;
    logic [5:0] z, c;
    send_frag(4'd3, 6'd10, 6'd5, pulses);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL first_req_pulses: %0d pulses, want 1", pulses);
    end
    checks++;
    if (pass_cnt !== 16'd1 || reject_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_cnt: pass=%0d reject=%0d busy=%b, want 1 0 0",
               pass_cnt, reject_cnt, busy);
    end
    read_addr(4'd3, z, c);
    checks++;
    if (z !== 6'd10 || c !== 6'd5) begin
      errors++;
      $display("FAIL first_rd: depth=%0d color=%0d, want 10 5", z, c);
    end
  endtask

  task automatic test_reject();
    int pulses;
    logic [5:0] z, c;
    send_frag(4'd3, 6'd10, 6'd9, pulses);   // equal depth
    send_frag(4'd3, 6'd12, 6'd9, pulses);   // farther
    checks++;
    if (reject_cnt !== 16'd2 || pass_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reject_cnt: pass=%0d reject=%0d, want 1 2", pass_cnt, reject_cnt);
    end
    read_addr(4'd3, z, c);
    checks++;
    if (z !== 6'd10 || c !== 6'd5) begin
      errors++;
      $display("FAIL reject_rd: depth=%0d color=%0d, want 10 5", z, c);
    end
  endtask

  task automatic test_second_pass();
    int pulses;
    logic [5:0] z, c;
    rd_addr = 4'd3;
    send_frag(4'd3, 6'd2, 6'd7, pulses);
    // Readback registered on the TEST edge must see the pre-write entry.
    checks++;
    if (depth_out !== 6'd10 || color_out !== 6'd5) begin
      errors++;
      $display("FAIL same_cycle_rd: depth=%0d color=%0d, want 10 5", depth_out, color_out);
    end
    checks++;
    if (pass_cnt !== 16'd2 || reject_cnt !== 16'd2) begin
      errors++;
      $display("FAIL second_cnt: pass=%0d reject=%0d, want 2 2", pass_cnt, reject_cnt);
    end
    read_addr(4'd3, z, c);
    checks++;
    if (z !== 6'd2 || c !== 6'd7) begin
      errors++;
      $display("FAIL second_rd: depth=%0d color=%0d, want 2 7", z, c);
    end
    for (int k = 0; k < 3; k++) begin
      logic [3:0] a;
      a = (k == 0) ? 4'd0 : (k == 1) ? 4'd4 : 4'd15;
      read_addr(a, z, c);
      checks++;
      if (z !== 6'h3F || c !== 6'h00) begin
        errors++;
        $display("FAIL untouched[%0d]: depth=%h color=%h, want 3f 00", a, z, c);
      end
    end
  endtask

  task automatic test_clear_during_wait();
    int cyc;
    logic [5:0] z, c;
    fill = 8'd1;
    tick();                       // REQ
    fill = 8'd0;
    tick();                       // WAIT
    clear = 1'b1;
    tick();                       // still WAIT, clear now pending
    clear   = 1'b0;
    ack_in  = 1'b1;
    frag_in = {4'd4, 6'd1, 6'd1};
    rd_addr = 4'd4;
    tick();                       // TEST
    ack_in = 1'b0;
    fill   = 8'd1;                // pending clear must beat a waiting fragment
    tick();                       // IDLE, fragment written
    checks++;
    if (pass_cnt !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_inflight: pass=%0d busy=%b, want 3 0", pass_cnt, busy);
    end
    tick();                       // CLEAR
    fill = 8'd0;
    checks++;
    if (busy !== 1'b1 || req_out !== 1'b0 || pass_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clear_entry: busy=%b req=%b pass=%0d reject=%0d, want 1 0 0 0",
               busy, req_out, pass_cnt, reject_cnt);
    end
    checks++;
    if (depth_out !== 6'd1 || color_out !== 6'd1) begin
      errors++;
      $display("FAIL clear_written: depth=%0d color=%0d, want 1 1", depth_out, color_out);
    end
    wait_not_busy(cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL clear_time: busy fell after %0d cycles, want 16", cyc);
    end
    read_addr(4'd4, z, c);
    checks++;
    if (z !== 6'h3F || c !== 6'h00 || pass_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clear_after: depth=%h color=%h pass=%0d reject=%0d, want 3f 00 0 0",
               z, c, pass_cnt, reject_cnt);
    end
  endtask

  task automatic test_wait_hold_and_reset();
    int pulses;
    int idle_seen;
    int cyc;
    logic [5:0] z, c;
    send_frag(4'd6, 6'd20, 6'd3, pulses);
    // Long stall in WAIT, then complete normally.
    fill = 8'd1;
    tick();                       // REQ
    fill = 8'd0;
    tick();                       // WAIT
    frag_in   = {4'd6, 6'd5, 6'd9};
    pulses    = 0;
    idle_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (req_out) pulses++;
      if (!busy) idle_seen++;
    end
    checks++;
    if (pulses !== 0 || idle_seen !== 0) begin
      errors++;
      $display("FAIL hold_req: req pulses=%0d idle cycles=%0d, want 0 0", pulses, idle_seen);
    end
    checks++;
    if (pass_cnt !== 16'd1 || reject_cnt !== 16'd0) begin
      errors++;
      $display("FAIL hold_cnt: pass=%0d reject=%0d, want 1 0", pass_cnt, reject_cnt);
    end
    ack_in = 1'b1;
    tick();                       // TEST
    ack_in = 1'b0;
    tick();                       // IDLE
    read_addr(4'd6, z, c);
    checks++;
    if (z !== 6'd5 || c !== 6'd9 || pass_cnt !== 16'd2) begin
      errors++;
      $display("FAIL hold_done: depth=%0d color=%0d pass=%0d, want 5 9 2", z, c, pass_cnt);
    end
    // Stall again and reset at cycle 20 while an ack is presented.
    fill = 8'd1;
    tick();                       // REQ
    fill = 8'd0;
    tick();                       // WAIT
    frag_in = {4'd6, 6'd1, 6'd2};
    for (int i = 0; i < 20; i++) tick();
    reset  = 1'b1;
    ack_in = 1'b1;
    tick();
    reset  = 1'b0;
    ack_in = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_out !== 1'b0 || pass_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b req=%b pass=%0d reject=%0d, want 1 0 0 0",
               busy, req_out, pass_cnt, reject_cnt);
    end
    checks++;
    if (depth_out !== 6'd0 || color_out !== 6'd0) begin
      errors++;
      $display("FAIL midreset_rd: depth=%h color=%h, want 0 0", depth_out, color_out);
    end
    wait_not_busy(cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL midreset_time: busy fell after %0d cycles, want 16", cyc);
    end
    read_addr(4'd6, z, c);
    checks++;
    if (z !== 6'h3F || c !== 6'h00 || pass_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_after: depth=%h color=%h pass=%0d reject=%0d, want 3f 00 0 0",
               z, c, pass_cnt, reject_cnt);
    end
  endtask

  initial begin
    reset   = 1'b1;
    fill    = 8'd0;
    frag_in = 16'd0;
    ack_in  = 1'b0;
    clear   = 1'b0;
    rd_addr = 4'd0;
    test_reset();
    test_first_pass();
    test_reject();
    test_second_pass();
    test_clear_during_wait();
    test_wait_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/zbuffer_depth_test.md
ZBUFFER_DEPTH_TEST -- requirements
Module: zbuffer_depth_test

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the pixel address width; the buffer holds 2^ADDR_W entries.
REQ-002 Parameter Z_W, default 6, SHALL set the depth width.
REQ-003 Parameter COLOR_W, default 6, SHALL set the colour width; FRAG_W = ADDR_W+Z_W+COLOR_W (16 by default).
REQ-004 Parameter FILL_W, default 8, SHALL match the upstream FIFO occupancy width.
REQ-005 clk  in  1  the single clock; all state SHALL change on its rising edge only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 fill  in  FILL_W  upstream FIFO occupancy; nonzero means a fragment is available.
REQ-008 frag_in  in  FRAG_W  fragment {addr[MSB], z, color[LSB]} from the FIFO, valid when ack_in=1.
REQ-009 ack_in  in  1  upstream acknowledge qualifying frag_in.
REQ-010 req_out  out  1  one-cycle pop request to the FIFO.
REQ-011 clear  in  1  request to reinitialise the whole buffer.
REQ-012 rd_addr  in  ADDR_W  readback address.
REQ-013 color_out  out  COLOR_W  stored colour at rd_addr, registered.
REQ-014 depth_out  out  Z_W  stored depth at rd_addr, registered.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 pass_cnt  out  16  count of fragments written.
REQ-017 reject_cnt  out  16  count of fragments discarded.

Function
REQ-018 The block SHALL hold internal depth[2^ADDR_W] and color[2^ADDR_W] arrays with combinational read and synchronous write.
REQ-019 The FSM SHALL have states CLEAR, IDLE, REQ, WAIT, TEST.
REQ-020 CLEAR: write depth[k]=all-ones and color[k]=0, with k running 0 to 2^ADDR_W-1 at one entry per cycle; after the cycle writing the last entry, go to IDLE.
REQ-021 IDLE: a pending clear SHALL go to CLEAR with priority; otherwise, fill!=0 SHALL go to REQ; otherwise, stay in IDLE.
REQ-022 REQ: assert req_out=1 for exactly this one cycle, then go to WAIT; req_out SHALL be 0 in all other states.
REQ-023 WAIT: on ack_in=1, capture frag_in into an internal register and go to TEST; with ack_in=0, stay in WAIT indefinitely.
REQ-024 ack_in SHALL be ignored in every state except WAIT.
REQ-025 TEST pass: if captured z < depth[addr] (unsigned, strict), write depth[addr]=z and color[addr]=color in this cycle, and increment pass_cnt.
REQ-026 TEST reject: otherwise (including z equal to the stored depth), leave memory unchanged and increment reject_cnt.
REQ-027 TEST SHALL always return to IDLE after one cycle, giving a minimum of 4 cycles per fragment (IDLE, REQ, WAIT, TEST).
REQ-028 pass_cnt and reject_cnt SHALL saturate at 16'hFFFF.
REQ-029 Entering CLEAR SHALL zero both counters.
REQ-030 A clear=1 seen in any cycle SHALL set a pending flag, cleared on entering CLEAR; clear asserted in non-IDLE states SHALL therefore take effect at the next IDLE, without aborting the fragment in flight.
REQ-031 color_out and depth_out SHALL update one cycle after rd_addr with the stored values.
REQ-032 A readback in the same cycle as a TEST write to the same address SHALL return the pre-write value.

Reset
REQ-033 reset=1 SHALL force state CLEAR, k=0, pass_cnt=0, reject_cnt=0, req_out=0, busy=1, pending-clear flag=0, color_out=0 and depth_out=0.
REQ-034 Reset asserted mid-transaction SHALL abandon any captured fragment with no memory write, then re-run the full clear.
REQ-035 After reset, busy SHALL fall exactly 2^ADDR_W cycles after reset deasserts (16 with defaults).
REQ-036 Arrays SHALL need no reset beyond the CLEAR sweep.

Verification
REQ-037 Reset, then read back every address: depth_out=6'h3F and color_out=0 for all 16 entries; busy low after 16 cycles.
REQ-038 fill=1, then ack_in one cycle after req_out with frag {addr=3,z=10,color=5}: req_out pulses once; pass_cnt=1; read addr 3 gives z=10, color=5.
REQ-039 Follow with {3,z=10,color=9} then {3,z=12,color=9}: reject_cnt=2; addr 3 still gives z=10, color=5.
REQ-040 Follow with {3,z=2,color=7}: pass_cnt=2; addr 3 gives z=2, color=7; other addresses unchanged.
REQ-041 Assert clear during WAIT, then ack {4,z=1,color=1}: the fragment is written, then CLEAR runs; addr 4 reads z=6'h3F, color 0; counters read 0.
REQ-042 Hold ack_in=0 for 50 cycles in WAIT: no req_out re-pulse and no counter change; pulse reset at cycle 20 of the wait: state returns to CLEAR and no write occurs.
